mmc1_regs: RTL and testbench

MMC1_REGS -- requirements
Module: mmc1_regs

---
 rtl/mmc1_regs.sv | 157 +++++++++++++++
 tb/tb_mmc1_regs.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc1_regs.sv
// MMC1 mapper register file: serial 5-bit load port, control/CHR/PRG registers and the
// combinational bank/mirroring outputs derived from them.
//
// Ports:
//   clk_cpu    - single clock; all state updates on its rising edge
//   rst_n      - asynchronous active-low reset
//   m2         - CPU phi2, sampled on clk_cpu; a falling edge marks the end of a CPU cycle
//   cpu_addr   - CPU A14..A0
//   cpu_data_i - CPU write data
//   cpu_rw     - 1 = read, 0 = write
//   romsel     - active-low select for $8000-$FFFF
//   ppu_addr   - PPU address
//   prg_a      - PRG ROM A17..A14
//   chr_a      - CHR A16..A12
//   ciram_a10  - nametable select
//   prg_ram_en - high when $6000-$7FFF PRG RAM is enabled
//
// Build option: define MMC1_CONSEC_WRITE_FILTER_EN to ignore a write whose preceding CPU
// cycle was also a $8000-$FFFF write (read-modify-write double-write suppression).

module mmc1_regs #(
    parameter logic [3:0] LAST_BANK = 4'hF
) (
    input  logic        clk_cpu,
    input  logic        rst_n,
    input  logic        m2,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_rw,
    input  logic        romsel,
    input  logic [13:0] ppu_addr,
    output logic [3:0]  prg_a,
    output logic [4:0]  chr_a,
    output logic        ciram_a10,
    output logic        prg_ram_en
);

    localparam logic [4:0] ShiftEmpty = 5'b10000;
    localparam logic [4:0] CtrlReset  = 5'h0C;

    logic       m2_d, m2_q, m2_qq_d, m2_qq;
    logic [4:0] shift_d, shift_q;
    logic [4:0] control_d, control_q;
    logic [4:0] chr0_d, chr0_q;
    logic [4:0] chr1_d, chr1_q;
    logic [4:0] prg_d, prg_q;
    logic       m2_fall, is_wr, accept;
    logic [4:0] load_val;

`ifdef MMC1_CONSEC_WRITE_FILTER_EN
    logic wr_prev_d, wr_prev_q;
`endif

    always_comb begin
        m2_d      = m2;
        m2_qq_d   = m2_q;
        shift_d   = shift_q;
        control_d = control_q;
        chr0_d    = chr0_q;
        chr1_d    = chr1_q;
        prg_d     = prg_q;

        // One fall of the registered phi2 per CPU cycle.
        m2_fall  = m2_qq & ~m2_q;
        is_wr    = ~cpu_rw & ~romsel;
        load_val = {cpu_data_i[0], shift_q[4:1]};

`ifdef MMC1_CONSEC_WRITE_FILTER_EN
        wr_prev_d = wr_prev_q;
        if (m2_fall) begin
            wr_prev_d = is_wr;
        end
        accept = m2_fall & is_wr & ~wr_prev_q;
`else
        accept = m2_fall & is_wr;
`endif

        if (accept) begin
            if (cpu_data_i[7]) begin
                // Reload wins even when this would have been the fifth write.
                shift_d        = ShiftEmpty;
                control_d[3:2] = 2'b11;
            end else if (shift_q[0]) begin
                // Marker bit reached bit 0: this write completes the 5-bit value.
                shift_d = ShiftEmpty;
                unique case (cpu_addr[14:13])
                    2'd0: control_d = load_val;
                    2'd1: chr0_d    = load_val;
                    2'd2: chr1_d    = load_val;
                    2'd3: prg_d     = load_val;
                    default: ;
                endcase
            end else begin
                shift_d = load_val;
            end
        end
    end

    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            m2_q      <= 1'b0;
            m2_qq     <= 1'b0;
            shift_q   <= ShiftEmpty;
            control_q <= CtrlReset;
            chr0_q    <= 5'h00;
            chr1_q    <= 5'h00;
            prg_q     <= 5'h00;
        end else begin
            m2_q      <= m2_d;
            m2_qq     <= m2_qq_d;
            shift_q   <= shift_d;
            control_q <= control_d;
            chr0_q    <= chr0_d;
            chr1_q    <= chr1_d;
            prg_q     <= prg_d;
        end
    end

`ifdef MMC1_CONSEC_WRITE_FILTER_EN
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            wr_prev_q <= 1'b0;
        end else begin
            wr_prev_q <= wr_prev_d;
        end
    end
`endif

    always_comb begin
        unique case (control_q[1:0])
            2'd0: ciram_a10 = 1'b0;
            2'd1: ciram_a10 = 1'b1;
            2'd2: ciram_a10 = ppu_addr[10];
            2'd3: ciram_a10 = ppu_addr[11];
            default: ciram_a10 = 1'b0;
        endcase

        unique case (control_q[3:2])
            2'd0, 2'd1: prg_a = {prg_q[3:1], cpu_addr[14]};
            2'd2:       prg_a = cpu_addr[14] ? prg_q[3:0] : 4'h0;
            2'd3:       prg_a = cpu_addr[14] ? LAST_BANK : prg_q[3:0];
            default:    prg_a = 4'h0;
        endcase

        if (control_q[4]) begin
            chr_a = ppu_addr[12] ? chr1_q : chr0_q;
        end else begin
            chr_a = {chr0_q[4:1], ppu_addr[12]};
        end

        prg_ram_en = ~prg_q[4];
    end

    logic unused_inputs;
    assign unused_inputs = ^{cpu_addr[12:0], cpu_data_i[6:1], ppu_addr[13], ppu_addr[9:0]};

endmodule

// File: tb/tb_mmc1_regs.sv
module tb_mmc1_regs;

    logic        clk_cpu = 1'b0;
    logic        rst_n   = 1'b0;
    logic        m2      = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [7:0]  cpu_data_i = '0;
    logic        cpu_rw  = 1'b1;
    logic        romsel  = 1'b1;
    logic [13:0] ppu_addr = '0;
    logic [3:0]  prg_a;
    logic [4:0]  chr_a;
    logic        ciram_a10;
    logic        prg_ram_en;

    int checks = 0;
    int errors = 0;

    // Reference model: registers as plain integers, serial load as a bit counter.
    int m_ctrl, m_chr0, m_chr1, m_prg;
    int m_acc, m_cnt;
    bit m_prev_wr;

    mmc1_regs #(.LAST_BANK(4'hF)) dut (
        .clk_cpu    (clk_cpu),
        .rst_n      (rst_n),
        .m2         (m2),
        .cpu_addr   (cpu_addr),
        .cpu_data_i (cpu_data_i),
        .cpu_rw     (cpu_rw),
        .romsel     (romsel),
        .ppu_addr   (ppu_addr),
        .prg_a      (prg_a),
        .chr_a      (chr_a),
        .ciram_a10  (ciram_a10),
        .prg_ram_en (prg_ram_en)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic model_reset();
        m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
        m_acc = 0; m_cnt = 0; m_prev_wr = 0;
    endtask

    task automatic model_cycle(bit wr, logic [15:0] a, logic [7:0] d);
        bit wr8, acc_ok;
        wr8 = wr && a[15];
        acc_ok = wr8;
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
        if (m_prev_wr) acc_ok = 0;
`endif
        m_prev_wr = wr8;
        if (acc_ok) begin
            if (d[7]) begin
                m_acc = 0; m_cnt = 0;
                m_ctrl = m_ctrl | 12;
            end else begin
                m_acc = m_acc + (int'(d[0]) << m_cnt);
                m_cnt = m_cnt + 1;
                if (m_cnt == 5) begin
                    case ((int'(a) >> 13) & 3)
                        0: m_ctrl = m_acc;
                        1: m_chr0 = m_acc;
                        2: m_chr1 = m_acc;
                        default: m_prg = m_acc;
                    endcase
                    m_acc = 0; m_cnt = 0;
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_prg(logic a14);
        int mode, b;
        mode = (m_ctrl >> 2) & 3;
        if (mode < 2)       b = (m_prg & 14) + int'(a14);     // 32 KiB switching
        else if (mode == 2) b = a14 ? (m_prg & 15) : 0;       // first bank fixed
        else                b = a14 ? 15 : (m_prg & 15);      // last bank fixed
        return 4'(b);
    endfunction

    function automatic logic [4:0] exp_chr(logic p12);
        if ((m_ctrl & 16) != 0) return 5'(p12 ? m_chr1 : m_chr0);
        return 5'((m_chr0 & 30) + int'(p12));
    endfunction

    function automatic logic exp_ciram(logic [13:0] pa);
        case (m_ctrl & 3)
            0: return 1'b0;
            1: return 1'b1;
            2: return pa[10];
            default: return pa[11];
        endcase
    endfunction

    task automatic check1(string tag, int got, int expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // Probe all four combinations of cpu A14 / PPU A12 against the model.
    task automatic check_outputs(string tag);
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 15'($urandom);
            cpu_addr[14] = i[0];
            ppu_addr = 14'($urandom);
            ppu_addr[12] = i[1];
            #1;
            checks++;
            assert (prg_a === exp_prg(cpu_addr[14])) else begin
                errors++;
                $error("FAIL %s prg_a: observed %0h expected %0h", tag, prg_a, exp_prg(cpu_addr[14]));
            end
            checks++;
            assert (chr_a === exp_chr(ppu_addr[12])) else begin
                errors++;
                $error("FAIL %s chr_a: observed %0h expected %0h", tag, chr_a, exp_chr(ppu_addr[12]));
            end
            checks++;
            assert (ciram_a10 === exp_ciram(ppu_addr)) else begin
                errors++;
                $error("FAIL %s ciram_a10: observed %0b expected %0b", tag, ciram_a10,
                       exp_ciram(ppu_addr));
            end
            checks++;
            assert (prg_ram_en === ((m_prg & 16) == 0)) else begin
                errors++;
                $error("FAIL %s prg_ram_en: observed %0b expected %0b", tag, prg_ram_en,
                       (m_prg & 16) == 0);
            end
        end
    endtask

    // One CPU cycle: phi2 high for 3 clocks, low for 4; bus held throughout.
    task automatic cpu_cycle(bit wr, logic [15:0] a, logic [7:0] d);
        @(posedge clk_cpu); #1;
        cpu_addr = a[14:0]; romsel = ~a[15]; cpu_rw = ~wr; cpu_data_i = d;
        m2 = 1'b1;
        repeat (3) @(posedge clk_cpu);
        #1 m2 = 1'b0;
        repeat (4) @(posedge clk_cpu);
        #1 cpu_rw = 1'b1;
        model_cycle(wr, a, d);
    endtask

    // Write followed by a read cycle, so the write filter never applies.
    task automatic wr_sep(logic [15:0] a, logic [7:0] d);
        cpu_cycle(1, a, d);
        cpu_cycle(0, 16'h8000, 8'h00);
    endtask

    task automatic load5(logic [15:0] a, logic [4:0] v);
        for (int i = 0; i < 5; i++) wr_sep(a, {7'h0, v[i]});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk_cpu);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Reset state.
        cpu_addr = 15'h4000; ppu_addr = 14'h0800; #1;
        check1("reset prg_a c000", int'(prg_a), 15);
        check1("reset ciram", int'(ciram_a10), 0);
        check1("reset prg_ram_en", int'(prg_ram_en), 1);
        check_outputs("reset");

        // Control load 1,1,0,1,0 -> 0x0B.
        load5(16'h8000, 5'b01011);
        cpu_addr = 15'h0000; ppu_addr = 14'h0800; #1;
        check1("ctrl ciram=ppu11", int'(ciram_a10), 1);
        check1("ctrl prg_a 8000", int'(prg_a), 0);
        check_outputs("ctrl");

        // Reload sets PRG mode 3, then PRG load 0,1,1,0,0 -> 6.
        wr_sep(16'h8000, 8'h80);
        load5(16'hE000, 5'b00110);
        cpu_addr = 15'h0000; #1;
        check1("prg prg_a 8000", int'(prg_a), 6);
        cpu_addr = 15'h4000; #1;
        check1("prg prg_a c000", int'(prg_a), 15);
        check1("prg prg_ram_en", int'(prg_ram_en), 1);
        check_outputs("prg");

        // Mid-sequence reload, then chr0 = 1.
        wr_sep(16'hA000, 8'h01);
        wr_sep(16'hA000, 8'h01);
        wr_sep(16'hA000, 8'h80);
        load5(16'hA000, 5'b00001);
        check_outputs("reload");

        // Back-to-back writes: filtered or not depending on build.
        do_reset();
        cpu_cycle(1, 16'h8000, 8'h01);
        cpu_cycle(1, 16'h8000, 8'h00);
        cpu_cycle(0, 16'h8000, 8'h00);
        wr_sep(16'h8000, 8'h01);
        wr_sep(16'h8000, 8'h01);
        wr_sep(16'h8000, 8'h00);
        check_outputs("filter");
        wr_sep(16'h8000, 8'h00);
        check_outputs("filter2");

        // Asynchronous reset mid-sequence.
        do_reset();
        load5(16'h8000, 5'b00011);
        wr_sep(16'h8000, 8'h01);
        wr_sep(16'h8000, 8'h01);
        wr_sep(16'h8000, 8'h01);
        ppu_addr = 14'h0800;
        @(posedge clk_cpu); #3;
        rst_n = 1'b0;
        #1;
        check1("async ciram", int'(ciram_a10), 0);
        #3 rst_n = 1'b1;
        model_reset();
        load5(16'h8000, 5'b10010);
        check_outputs("async");

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            logic [15:0] a;
            logic [7:0]  d;
            a = 16'($urandom);
            a[15:13] = 3'($urandom_range(3, 7));
            d = 8'($urandom);
            d[7] = ($urandom_range(0, 9) == 0);
            cpu_cycle($urandom_range(0, 3) != 0, a, d);
            if (n % 10 == 9) check_outputs("random");
        end
        check_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
